// File: rtl/pll_reset_sequencer.sv
// Reset sequencer for the 50 MHz PLL domain: waits for a stable lock, holds the system
// reset a little longer, and records lock-loss events seen while running.
module pll_reset_sequencer #(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES        = 16,
    parameter int unsigned CNT_W              = 16,
    parameter int unsigned LOSS_W             = 8
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic              locked,
    input  logic              clear_status,
    output logic              sys_reset_n,
    output logic              sys_ready,
    output logic [1:0]        state,
    output logic              lock_lost,
    output logic [LOSS_W-1:0] lock_lost_count
);

    typedef enum logic [1:0] {
        StReset    = 2'd0,
        StWaitLock = 2'd1,
        StHold     = 2'd2,
        StRun      = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] LockLast = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_s;

    state_e                 r_state;
    state_e                 w_state_d;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_d;
    logic                   w_loss;

    logic                   r_sys_reset_n;
    logic                   r_sys_ready;
    logic                   r_lock_lost;
    logic                   w_lock_lost_d;
    logic [LOSS_W-1:0]      r_loss_cnt;
    logic [LOSS_W-1:0]      w_loss_cnt_d;

    // 'locked' is asynchronous to clock_in; only the last stage is used.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
        end
    end

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_loss    = 1'b0;
        case (r_state)
            StReset: begin
                w_state_d = StWaitLock;
                w_cnt_d   = '0;
            end
            StWaitLock: begin
                if (!w_lock_s) begin
                    w_cnt_d = '0;
                end else if (r_cnt == LockLast) begin
                    w_state_d = StHold;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StHold: begin
                if (!w_lock_s) begin
                    w_state_d = StWaitLock;
                    w_cnt_d   = '0;
                end else if (r_cnt == HoldLast) begin
                    w_state_d = StRun;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StRun: begin
                if (!w_lock_s) begin
                    w_state_d = StWaitLock;
                    w_cnt_d   = '0;
                    w_loss    = 1'b1;
                end
            end
            default: begin
                w_state_d = StReset;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StReset;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Outputs follow the next state so they flip on the same edge as entry/exit of RUN.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_sys_reset_n <= 1'b0;
            r_sys_ready   <= 1'b0;
        end else begin
            r_sys_reset_n <= (w_state_d == StRun);
            r_sys_ready   <= (w_state_d == StRun);
        end
    end

    // A clear coinciding with a loss is applied first, so the loss still registers.
    always_comb begin
        w_lock_lost_d = r_lock_lost;
        w_loss_cnt_d  = r_loss_cnt;
        if (clear_status) begin
            w_lock_lost_d = 1'b0;
            w_loss_cnt_d  = '0;
        end
        if (w_loss) begin
            w_lock_lost_d = 1'b1;
            if (w_loss_cnt_d != {LOSS_W{1'b1}}) begin
                w_loss_cnt_d = w_loss_cnt_d + LOSS_W'(1);
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_lost <= 1'b0;
            r_loss_cnt  <= '0;
        end else begin
            r_lock_lost <= w_lock_lost_d;
            r_loss_cnt  <= w_loss_cnt_d;
        end
    end

    assign sys_reset_n     = r_sys_reset_n;
    assign sys_ready       = r_sys_ready;
    assign state           = r_state;
    assign lock_lost       = r_lock_lost;
    assign lock_lost_count = r_loss_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with SYNC_STAGES=2, LOCK_STABLE_CYCLES=8,
// HOLD_CYCLES=4, LOSS_W=2.
module tb_pll_reset_sequencer;

    logic       clk;
    logic       reset_n;
    logic       locked;
    logic       clear_status;
    logic       sys_reset_n;
    logic       sys_ready;
    logic [1:0] state;
    logic       lock_lost;
    logic [1:0] lock_lost_count;

    int n_cmp;
    int n_err;

    pll_reset_sequencer #(
        .SYNC_STAGES       (2),
        .LOCK_STABLE_CYCLES(8),
        .HOLD_CYCLES       (4),
        .CNT_W             (16),
        .LOSS_W            (2)
    ) dut (
        .clock_in       (clk),
        .reset_n        (reset_n),
        .locked         (locked),
        .clear_status   (clear_status),
        .sys_reset_n    (sys_reset_n),
        .sys_ready      (sys_ready),
        .state          (state),
        .lock_lost      (lock_lost),
        .lock_lost_count(lock_lost_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b1;
        locked       = 1'b0;
        clear_status = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        tick();
        tick();
        n_cmp++;
        if (state !== 2'd0) begin
            n_err++; $display("FAIL reset_state: got %0d want 0", state);
        end
        n_cmp++;
        if ({sys_reset_n, sys_ready} !== 2'b00) begin
            n_err++; $display("FAIL reset_outs: got %b want 00", {sys_reset_n, sys_ready});
        end
        n_cmp++;
        if ({lock_lost, lock_lost_count} !== 3'b000) begin
            n_err++; $display("FAIL reset_status: got %b want 000", {lock_lost, lock_lost_count});
        end
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (state !== 2'd0) begin
            n_err++; $display("FAIL release_no_edge_state: got %0d want 0", state);
        end
    endtask

    task automatic test_wait_no_lock();
        for (int c = 1; c <= 50; c++) begin
            tick();
            n_cmp++;
            if ({state, sys_reset_n, sys_ready} !== 4'b0100) begin
                n_err++;
                $display("FAIL wait_no_lock cyc %0d: got state=%0d rst_n=%b rdy=%b want 1/0/0",
                         c, state, sys_reset_n, sys_ready);
            end
        end
    endtask

    task automatic test_lock_acquire();
        logic [1:0] exp_state;
        locked = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            exp_state = (e < 10) ? 2'd1 : (e < 14) ? 2'd2 : 2'd3;
            n_cmp++;
            if (state !== exp_state || sys_reset_n !== (e == 14) || sys_ready !== (e == 14)) begin
                n_err++;
                $display("FAIL acquire edge %0d: got state=%0d rst_n=%b rdy=%b want %0d/%b/%b",
                         e, state, sys_reset_n, sys_ready, exp_state, e == 14, e == 14);
            end
        end
    endtask

    task automatic test_wait_glitch();
        logic [1:0] exp_state;
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        locked  = 1'b0;
        tick();
        locked = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            if (c == 6) locked = 1'b0;
            tick();
            n_cmp++;
            if (state !== 2'd1) begin
                n_err++; $display("FAIL glitch_wait cyc %0d: got state=%0d want 1", c, state);
            end
        end
        locked = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            exp_state = (e < 10) ? 2'd1 : (e < 14) ? 2'd2 : 2'd3;
            n_cmp++;
            if (state !== exp_state || sys_reset_n !== (e == 14)) begin
                n_err++;
                $display("FAIL glitch_reacquire edge %0d: got state=%0d rst_n=%b want %0d/%b",
                         e, state, sys_reset_n, exp_state, e == 14);
            end
        end
    endtask

    task automatic test_run_loss();
        logic [1:0] exp_cnt;
        for (int i = 0; i < 4; i++) begin
            exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
            locked = 1'b0;
            for (int e = 1; e <= 3; e++) begin
                tick();
                if (e < 3) begin
                    n_cmp++;
                    if (state !== 2'd3 || sys_reset_n !== 1'b1) begin
                        n_err++;
                        $display("FAIL loss%0d early edge %0d: got state=%0d rst_n=%b want 3/1",
                                 i, e, state, sys_reset_n);
                    end
                end
            end
            n_cmp++;
            if ({state, sys_reset_n, sys_ready, lock_lost} !== 5'b01001 ||
                lock_lost_count !== exp_cnt) begin
                n_err++;
                $display("FAIL loss%0d: got state=%0d rst_n=%b rdy=%b lost=%b cnt=%0d want 1/0/0/1/%0d",
                         i, state, sys_reset_n, sys_ready, lock_lost, lock_lost_count, exp_cnt);
            end
            locked = 1'b1;
            repeat (14) tick();
            n_cmp++;
            if (state !== 2'd3 || sys_ready !== 1'b1) begin
                n_err++;
                $display("FAIL loss%0d recover: got state=%0d rdy=%b want 3/1", i, state, sys_ready);
            end
        end
    endtask

    task automatic test_clear_status();
        locked = 1'b0;
        tick();
        tick();
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        n_cmp++;
        if (lock_lost !== 1'b1 || lock_lost_count !== 2'd1 || state !== 2'd1) begin
            n_err++;
            $display("FAIL clear_coincident: got lost=%b cnt=%0d state=%0d want 1/1/1",
                     lock_lost, lock_lost_count, state);
        end
        locked = 1'b1;
        repeat (14) tick();
        n_cmp++;
        if (state !== 2'd3) begin
            n_err++; $display("FAIL clear_recover: got state=%0d want 3", state);
        end
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        n_cmp++;
        if (lock_lost !== 1'b0 || lock_lost_count !== 2'd0 || state !== 2'd3 ||
            sys_reset_n !== 1'b1) begin
            n_err++;
            $display("FAIL clear_alone: got lost=%b cnt=%0d state=%0d rst_n=%b want 0/0/3/1",
                     lock_lost, lock_lost_count, state, sys_reset_n);
        end
        locked = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (lock_lost !== 1'b1 || lock_lost_count !== 2'd1 || state !== 2'd1) begin
            n_err++;
            $display("FAIL loss_after_clear: got lost=%b cnt=%0d state=%0d want 1/1/1",
                     lock_lost, lock_lost_count, state);
        end
    endtask

    task automatic test_async_reset();
        locked = 1'b1;
        repeat (11) tick();
        n_cmp++;
        if (state !== 2'd2) begin
            n_err++; $display("FAIL hold_reached: got state=%0d want 2", state);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({state, sys_reset_n, sys_ready, lock_lost, lock_lost_count} !== 7'b0) begin
            n_err++;
            $display("FAIL async_hold: got state=%0d rst_n=%b rdy=%b lost=%b cnt=%0d want all 0",
                     state, sys_reset_n, sys_ready, lock_lost, lock_lost_count);
        end
        tick();
        reset_n = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 1 || e == 13 || e == 14) begin
                n_cmp++;
                if (state !== ((e == 1) ? 2'd1 : (e == 13) ? 2'd2 : 2'd3)) begin
                    n_err++;
                    $display("FAIL restart edge %0d: got state=%0d", e, state);
                end
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({state, sys_reset_n, sys_ready} !== 4'b0000) begin
            n_err++;
            $display("FAIL async_run: got state=%0d rst_n=%b rdy=%b want 0/0/0",
                     state, sys_reset_n, sys_ready);
        end
        tick();
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (state !== 2'd0) begin
            n_err++; $display("FAIL async_run_hold_reset: got state=%0d want 0", state);
        end
        tick();
        n_cmp++;
        if (state !== 2'd1 || sys_reset_n !== 1'b0) begin
            n_err++;
            $display("FAIL async_run_restart: got state=%0d rst_n=%b want 1/0", state, sys_reset_n);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_wait_no_lock();
        test_lock_acquire();
        test_wait_glitch();
        test_run_loss();
        test_clear_status();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
